mbist_march_ctrl: RTL

Self-contained March C- memory BIST sequencer for a single-port synchronous RAM, replacing the MATS+-style flow (w0/r0/w1/r1) and its external counter.
- Owns its address counter, direction control, write-data pattern, read compare and first-fail capture.
- Sits between the test-mode top level (start/done/fail) and the RAM under test, which it drives directly while busy.

---
 rtl/mbist_pkg.sv | 42 ++++
 rtl/mbist_addr_cnt.sv | 37 +++
 rtl/mbist_march_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- element tables and FSM state type for the MBIST sequencer
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NUM_ELEM = 6;

    // Bit i describes March element i: E0 up w0, E1 up r0w1, E2 up r1w0,
    // E3 down r0w1, E4 down r1w0, E5 up r0.
    localparam logic [NUM_ELEM-1:0] ELEM_UP    = 6'b100111;
    localparam logic [NUM_ELEM-1:0] ELEM_READ  = 6'b111110;
    localparam logic [NUM_ELEM-1:0] ELEM_WRITE = 6'b011111;
    localparam logic [NUM_ELEM-1:0] ELEM_REXP  = 6'b010100;
    localparam logic [NUM_ELEM-1:0] ELEM_WBIT  = 6'b001010;

    function automatic logic elem_up(input logic [2:0] e);
        return ELEM_UP[e];
    endfunction

    function automatic logic elem_has_read(input logic [2:0] e);
        return ELEM_READ[e];
    endfunction

    function automatic logic elem_has_write(input logic [2:0] e);
        return ELEM_WRITE[e];
    endfunction

    function automatic logic elem_rexp(input logic [2:0] e);
        return ELEM_REXP[e];
    endfunction

    function automatic logic elem_wbit(input logic [2:0] e);
        return ELEM_WBIT[e];
    endfunction

endpackage

// File: rtl/mbist_addr_cnt.sv
// rtl/mbist_addr_cnt.sv - up/down address counter with terminal-address carry
module mbist_addr_cnt #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_up,
    input  logic          load_down,
    input  logic          en,
    input  logic          up_down,
    output logic [AW-1:0] cnt,
    output logic          carry
);

    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_up)
            cnt_d = '0;
        else if (load_down)
            cnt_d = '1;
        else if (en)
            cnt_d = up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt   = cnt_q;
    assign carry = up_down ? (&cnt_q) : ~(|cnt_q);

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- BIST sequencer with read compare and first-fail capture
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_elem
);

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;
    logic [2:0]    elem_nxt;
    logic          load_up, load_down, cnt_en;
    logic [AW-1:0] cnt;
    logic          carry;
    logic          start_ok;

    logic          cmp_valid_q, cmp_exp_q;
    logic [AW-1:0] cmp_addr_q;
    logic [2:0]    cmp_elem_q;
    logic          mismatch;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]    fail_elem_q, fail_elem_d;

    mbist_addr_cnt #(.AW(AW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_up   (load_up),
        .load_down (load_down),
        .en        (cnt_en),
        .up_down   (elem_up(elem_q)),
        .cnt       (cnt),
        .carry     (carry)
    );

    assign elem_nxt = elem_q + 3'd1;
    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        load_up   = 1'b0;
        load_down = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WR;
                    elem_d  = '0;
                    load_up = 1'b1;
                end
            end
            ST_WR: begin
                // Carry on the write closes the element; the next one starts with no gap.
                if (carry) begin
                    elem_d    = elem_nxt;
                    load_up   = elem_up(elem_nxt);
                    load_down = ~elem_up(elem_nxt);
                    state_d   = elem_has_read(elem_nxt) ? ST_RD : ST_WR;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = elem_has_read(elem_q) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                if (elem_has_write(elem_q))
                    state_d = ST_WR;
                else if (carry)
                    state_d = ST_DRAIN;
                else
                    cnt_en = 1'b1;
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = cnt;
        mem_we    = (state_q == ST_WR);
        mem_re    = (state_q == ST_RD);
        mem_wdata = mem_we ? {DW{elem_wbit(elem_q)}} : '0;
        busy      = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
    end

    assign mismatch = cmp_valid_q && (mem_rdata != {DW{cmp_exp_q}});

    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (start_ok) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            cmp_valid_q <= (state_q == ST_RD);
            cmp_exp_q   <= elem_rexp(elem_q);
            cmp_addr_q  <= cnt;
            cmp_elem_q  <= elem_q;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule
